// File: rtl/dlx_fetch_pkg.sv
// Shared types for the DLX instruction-fetch stage.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one queued fetch result {instruction word, its address}
//   INSTR_BYTES   : PC increment per instruction
package dlx_fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int ENTRY_IR_W  = 32;
    localparam int ENTRY_PC_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ENTRY_IR_W-1:0] ir;
        logic [ENTRY_PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_unit_buffer.sv
// Two-entry FIFO holding fetched words between IRAM and decode.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : discard all entries (wins over push/pop)
//   push/din : write one entry
//   pop      : remove head entry (ignored when empty)
//   head     : registered head entry
//   valid    : head entry present
//   count    : current occupancy (0..2)
module fetch_buffer
    import dlx_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    fetch_entry_t entry0_reg;
    fetch_entry_t entry1_reg;
    logic [1:0]   count_reg;
    logic [1:0]   wr_idx;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_reg != 2'd0) && !flush;
    // A full buffer accepts a push only when the head leaves the same cycle.
    assign do_push = push && !flush && ((count_reg != 2'd2) || do_pop);
    // Slot the new word lands in after any shift caused by a pop.
    assign wr_idx  = count_reg - {1'b0, do_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0_reg <= '0;
            entry1_reg <= '0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            count_reg <= 2'd0;
        end else begin
            if (do_push && (wr_idx == 2'd0)) begin
                entry0_reg <= din;
            end else if (do_pop) begin
                entry0_reg <= entry1_reg;
            end
            if (do_push && (wr_idx == 2'd1)) begin
                entry1_reg <= din;
            end
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head  = entry0_reg;
    assign valid = (count_reg != 2'd0);
    assign count = count_reg;

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: owns the fetch PC, issues IRAM reads, queues the
// returned words and presents {IR, PC, NPC} to decode with a valid/ready handshake.
// Branch redirects flush the queue and any in-flight read.
//   CLK, RST                   : clock, asynchronous active-high reset
//   IRAM_ADDRESS/ENABLE        : read request, held stable until IRAM_READY
//   IRAM_READY/DATA            : read response for the held request
//   BRANCH_TAKEN/TARGET        : single-cycle redirect request (target word aligned)
//   IR_OUT/PC_OUT/NPC_OUT      : head instruction, its address, address + 4
//   IR_VALID/IR_READY          : decode handshake
module dlx_fetch_unit
    import dlx_fetch_pkg::*;
#(
    parameter int                 IR_SIZE  = 32,
    parameter int                 PC_SIZE  = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [PC_SIZE-1:0] IRAM_ADDRESS,
    output logic               IRAM_ENABLE,
    input  logic               IRAM_READY,
    input  logic [IR_SIZE-1:0] IRAM_DATA,
    input  logic               BRANCH_TAKEN,
    input  logic [PC_SIZE-1:0] BRANCH_TARGET,
    output logic [IR_SIZE-1:0] IR_OUT,
    output logic [PC_SIZE-1:0] PC_OUT,
    output logic [PC_SIZE-1:0] NPC_OUT,
    output logic               IR_VALID,
    input  logic               IR_READY
);

    fetch_state_t       state_reg, state_next;
    logic [PC_SIZE-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PC_SIZE-1:0] target_reg, target_next;
    logic [PC_SIZE-1:0] branch_pc;
    logic [PC_SIZE-1:0] seq_pc;
    logic [PC_SIZE-1:0] head_pc;
    logic               buf_push;
    logic               buf_pop;
    logic               buf_valid;
    logic [1:0]         buf_count;
    logic [1:0]         occ_after;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;

    assign branch_pc = {BRANCH_TARGET[PC_SIZE-1:2], 2'b00};
    assign seq_pc    = fetch_pc_reg + PC_SIZE'(INSTR_BYTES);

    // A redirect voids both the returning word and the decode pop of this cycle.
    assign buf_push  = (state_reg == REQ) && IRAM_READY && !BRANCH_TAKEN;
    assign buf_pop   = buf_valid && IR_READY && !BRANCH_TAKEN;
    assign occ_after = buf_count + {1'b0, buf_push} - {1'b0, buf_pop};

    assign push_entry.ir = ENTRY_IR_W'(IRAM_DATA);
    assign push_entry.pc = ENTRY_PC_W'(fetch_pc_reg);

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        target_next   = target_reg;
        if (BRANCH_TAKEN) begin
            if (((state_reg == REQ) || (state_reg == DISCARD)) && !IRAM_READY) begin
                // Read still outstanding: wait it out, then jump (last redirect wins).
                state_next  = DISCARD;
                target_next = branch_pc;
            end else begin
                state_next    = REQ;
                fetch_pc_next = branch_pc;
            end
        end else begin
            case (state_reg)
                IDLE: state_next = REQ;
                REQ: begin
                    if (IRAM_READY) begin
                        fetch_pc_next = seq_pc;
                        // Keep occupancy + outstanding within the two queue slots.
                        state_next    = (occ_after < 2'd2) ? REQ : WAIT;
                    end
                end
                WAIT: begin
                    if (occ_after < 2'd2) begin
                        state_next = REQ;
                    end
                end
                DISCARD: begin
                    if (IRAM_READY) begin
                        fetch_pc_next = target_reg;
                        state_next    = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            target_reg   <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            target_reg   <= target_next;
        end
    end

    fetch_buffer u_buffer (
        .clk   (CLK),
        .rst   (RST),
        .flush (BRANCH_TAKEN),
        .push  (buf_push),
        .din   (push_entry),
        .pop   (buf_pop),
        .head  (head_entry),
        .valid (buf_valid),
        .count (buf_count)
    );

    // During DISCARD fetch_pc still holds the stale address, so the held
    // request stays on it until the memory answers.
    assign IRAM_ENABLE  = (state_reg == REQ) || (state_reg == DISCARD);
    assign IRAM_ADDRESS = IRAM_ENABLE ? fetch_pc_reg : '0;

    // Data outputs read as zero whenever nothing valid is presented.
    assign head_pc  = head_entry.pc[PC_SIZE-1:0];
    assign IR_VALID = buf_valid;
    assign IR_OUT   = buf_valid ? head_entry.ir[IR_SIZE-1:0] : '0;
    assign PC_OUT   = buf_valid ? head_pc : '0;
    assign NPC_OUT  = buf_valid ? (head_pc + PC_SIZE'(INSTR_BYTES)) : '0;

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Scoreboard bench for dlx_fetch_unit: directed scenarios push expected
// {IR, PC, NPC} records; a monitor compares every accepted decode handshake.
module tb_dlx_fetch_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] IRAM_ADDRESS;
    logic        IRAM_ENABLE;
    logic        IRAM_READY;
    logic [31:0] IRAM_DATA;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IR_OUT;
    logic [31:0] PC_OUT;
    logic [31:0] NPC_OUT;
    logic        IR_VALID;
    logic        IR_READY;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          accepted = 0;
    int          mem_delay = 2;
    int          mem_cnt   = 0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data  = '0;
    logic        stale_ready = 1'b0;
    logic        found;

    dlx_fetch_unit #(
        .IR_SIZE  (32),
        .PC_SIZE  (32),
        .RESET_PC (32'h0)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IRAM_ADDRESS  (IRAM_ADDRESS),
        .IRAM_ENABLE   (IRAM_ENABLE),
        .IRAM_READY    (IRAM_READY),
        .IRAM_DATA     (IRAM_DATA),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IR_OUT        (IR_OUT),
        .PC_OUT        (PC_OUT),
        .NPC_OUT       (NPC_OUT),
        .IR_VALID      (IR_VALID),
        .IR_READY      (IR_READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    // IRAM model: answers mem_delay cycles after a request is first seen.
    assign IRAM_READY = mem_ready | stale_ready;
    assign IRAM_DATA  = stale_ready ? 32'hBAD0_BAD0 : mem_data;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RST || !IRAM_ENABLE) begin
                mem_cnt   = 0;
                mem_ready = 1'b0;
            end else begin
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    mem_cnt   = 0;
                end
                mem_cnt++;
                if (mem_cnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    mem_data  = instr_of(IRAM_ADDRESS);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one line per accepted transfer, compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && IR_VALID && IR_READY && !BRANCH_TAKEN) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=pc %h required=no transfer", PC_OUT);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer pc=%h npc=%h ir=%h", PC_OUT, NPC_OUT, IR_OUT);
                    check("sb_ir", IR_OUT, e.ir);
                    check("sb_pc", PC_OUT, e.pc);
                    check("sb_npc", NPC_OUT, e.npc);
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] npc);
        exp_t e;
        e.ir  = instr_of(pc);
        e.pc  = pc;
        e.npc = npc;
        exp_q.push_back(e);
    endtask

    task automatic accept(input int n);
        int goal;
        int guard;
        goal  = accepted + n;
        guard = 0;
        IR_READY = 1'b1;
        while (accepted < goal && guard < 200) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        IR_READY = 1'b0;
        check("accept_count", accepted, goal);
    endtask

    // Leaves RST asserted at posedge+1; caller releases it.
    task automatic apply_reset();
        RST = 1'b1;
        BRANCH_TAKEN = 1'b0;
        IR_READY = 1'b0;
        stale_ready = 1'b0;
        mem_delay = 2;
        repeat (2) @(posedge CLK);
        #1;
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        RST = 1'b1;
        BRANCH_TAKEN = 1'b0;
        BRANCH_TARGET = '0;
        IR_READY = 1'b0;

        // Reset values
        apply_reset();
        check("rst_enable", IRAM_ENABLE, 0);
        check("rst_address", IRAM_ADDRESS, 0);
        check("rst_valid", IR_VALID, 0);
        check("rst_ir", IR_OUT, 0);
        check("rst_pc", PC_OUT, 0);
        check("rst_npc", NPC_OUT, 0);

        // 1: sequential fetch, decode always ready
        RST = 1'b0;
        expect_word(32'h00, 32'h04);
        expect_word(32'h04, 32'h08);
        expect_word(32'h08, 32'h0C);
        expect_word(32'h0C, 32'h10);
        expect_word(32'h10, 32'h14);
        accept(5);

        // 2: decode stalls, queue fills, fetch pauses, then resumes at 8
        apply_reset();
        RST = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t2_enable_low", IRAM_ENABLE, 0);
            check("t2_hold_pc", PC_OUT, 32'h0);
            check("t2_hold_ir", IR_OUT, instr_of(32'h0));
            @(posedge CLK);
            #1;
        end
        expect_word(32'h00, 32'h04);
        expect_word(32'h04, 32'h08);
        expect_word(32'h08, 32'h0C);
        expect_word(32'h0C, 32'h10);
        IR_READY = 1'b1;
        @(posedge CLK);
        #1;
        IR_READY = 1'b0;
        check("t2_resume_en", IRAM_ENABLE, 1);
        check("t2_resume_addr", IRAM_ADDRESS, 32'h08);
        accept(3);

        // 3: redirect while request to 0x10 is outstanding
        apply_reset();
        RST = 1'b0;
        mem_delay = 5;
        expect_word(32'h00, 32'h04);
        expect_word(32'h04, 32'h08);
        expect_word(32'h08, 32'h0C);
        expect_word(32'h0C, 32'h10);
        accept(4);
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h100;
        @(posedge CLK);
        #1;
        BRANCH_TAKEN = 1'b0;
        check("t3_valid", IR_VALID, 0);
        for (int i = 0; i < 3; i++) begin
            check("t3_held_en", IRAM_ENABLE, 1);
            check("t3_held_addr", IRAM_ADDRESS, 32'h10);
            if (i < 2) begin
                @(posedge CLK);
                #1;
            end
        end
        @(posedge CLK);
        #1;
        check("t3_new_addr", IRAM_ADDRESS, 32'h100);
        mem_delay = 2;
        expect_word(32'h100, 32'h104);
        expect_word(32'h104, 32'h108);
        accept(2);

        // 4: redirect coincident with IRAM_READY and a decode handshake
        apply_reset();
        RST = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge CLK);
            if (IRAM_READY && IR_VALID) found = 1'b1;
        end
        check("t4_setup", found, 1);
        #1;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h200;
        IR_READY = 1'b1;
        @(posedge CLK);
        #1;
        BRANCH_TAKEN = 1'b0;
        IR_READY = 1'b0;
        check("t4_valid", IR_VALID, 0);
        check("t4_en", IRAM_ENABLE, 1);
        check("t4_addr", IRAM_ADDRESS, 32'h200);
        expect_word(32'h200, 32'h204);
        expect_word(32'h204, 32'h208);
        accept(2);

        // 5: wrap at top of address space, then unaligned target
        apply_reset();
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        BRANCH_TAKEN = 1'b0;
        check("t5_addr_top", IRAM_ADDRESS, 32'hFFFF_FFFC);
        repeat (2) @(posedge CLK);
        #1;
        check("t5_addr_wrap", IRAM_ADDRESS, 32'h0);
        expect_word(32'hFFFF_FFFC, 32'h0000_0000);
        expect_word(32'h0000_0000, 32'h0000_0004);
        accept(2);
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h103;
        @(posedge CLK);
        #1;
        BRANCH_TAKEN = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (IRAM_ENABLE && IRAM_ADDRESS == 32'h100) found = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        check("t5_aligned_target", found, 1);
        expect_word(32'h100, 32'h104);
        expect_word(32'h104, 32'h108);
        accept(2);

        // 6: reset during DISCARD, stale READY after release
        apply_reset();
        RST = 1'b0;
        mem_delay = 5;
        @(posedge CLK);
        #1;
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h300;
        @(posedge CLK);
        #1;
        BRANCH_TAKEN = 1'b0;
        check("t6_discard_addr", IRAM_ADDRESS, 32'h0);
        check("t6_discard_en", IRAM_ENABLE, 1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("t6_rst_en", IRAM_ENABLE, 0);
        check("t6_rst_addr", IRAM_ADDRESS, 0);
        check("t6_rst_valid", IR_VALID, 0);
        mem_delay = 2;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        stale_ready = 1'b1;
        @(posedge CLK);
        #1;
        stale_ready = 1'b0;
        check("t6_first_en", IRAM_ENABLE, 1);
        check("t6_first_addr", IRAM_ADDRESS, 32'h0);
        check("t6_stale_valid", IR_VALID, 0);
        expect_word(32'h00, 32'h04);
        expect_word(32'h04, 32'h08);
        accept(2);

        check("sb_final_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
